// File: rtl/counter_ctrl_pkg.sv
// Shared types and mode-bit positions for the counter run controller.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int MODE_DIR_BIT    = 0;
    localparam int MODE_RELOAD_BIT = 1;

endpackage

// File: rtl/counter_prescaler.sv
// Tick divider for the run controller: tick every div+1 enabled clocks.
// Only instantiated when COUNTER_PRESCALE_EN is defined.
module counter_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr,
    input  logic               en,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;

    assign tick = en && (cnt == div);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/counter_run_ctrl.sv
// Start/stop sequencer for the counter datapath: load, step per tick, terminal count.
// Optional tick prescaler selected with COUNTER_PRESCALE_EN.
//
//   state | meaning
//   IDLE  | waiting for start; count holds last value
//   LOAD  | mode/limit captured; count gets its initial value next edge
//   RUN   | stepping once per tick toward the terminal value
module counter_run_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   limit,
    input  logic [PRESC_W-1:0] presc_div,
    output logic               ack,
    output logic               busy,
    output logic [WIDTH-1:0]   count,
    output logic               done
);

    state_t           state, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] count_d;
    logic             ack_d, busy_d, done_d;
    logic             tick;
    logic [WIDTH-1:0] init_val, term_val;
    logic             dir_down, reload;

    assign dir_down = mode_q[MODE_DIR_BIT];
    assign reload   = mode_q[MODE_RELOAD_BIT];
    assign init_val = dir_down ? limit_q : '0;
    assign term_val = dir_down ? '0 : limit_q;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESC_W(PRESC_W)
    ) u_presc (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state != RUN),
        .en   (busy),
        .div  (presc_div),
        .tick (tick)
    );
`else
    logic unused_presc;
    assign unused_presc = ^presc_div;
    assign tick         = 1'b1;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            mode_q  <= '0;
            limit_q <= '0;
            count   <= '0;
            ack     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            mode_q  <= mode_d;
            limit_q <= limit_d;
            count   <= count_d;
            ack     <= ack_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        mode_d  = mode_q;
        limit_d = limit_q;
        count_d = count;
        ack_d   = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (start && !stop) begin
                    mode_d  = mode;
                    limit_d = limit;
                    state_d = LOAD;
                    ack_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                if (stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    count_d = init_val;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                // stop outranks a terminal count landing on the same edge
                if (stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (tick) begin
                    if (count == term_val) begin
                        done_d = 1'b1;
                        if (reload) begin
                            count_d = init_val;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else if (dir_down) begin
                        count_d = count - WIDTH'(1);
                    end else begin
                        count_d = count + WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
